icache_prefetch: RTL and testbench

Instruction-cache next-line prefetcher between the I-cache and the memory bus. On a demand miss it issues up to `PF_LINES` sequential 8-byte line loads after the missing fetch block. It tracks outstanding memory tags and tells the I-cache where to write each returning line. It yields the bus whenever fetch has priority and aborts on a branch redirect.

---
 rtl/icache_prefetch.sv | 130 +++++++++++++
 tb/tb_icache_prefetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/icache_prefetch.sv
`default_nettype none
// ============================================================================
// icache_prefetch : next-line I-cache prefetcher with outstanding-tag table
// Revision 1.0
// ============================================================================
module icache_prefetch #(
   parameter int PF_LINES = 4,
   parameter int SYS_XLEN = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               Imem2pref_response,
   input  logic [3:0]               Imem2pref_tag,
   input  logic                     pf_bus_priority,
   input  logic                     branch,
   input  logic [2:0][SYS_XLEN-1:0] icache_req_addr,
   input  logic [2:0]               cachemem_valid,
   input  logic                     want_to_fetch,
   output logic                     icache_pref_done,
   output logic [1:0]               icache_pref_cmd,
   output logic [SYS_XLEN-1:0]      icache_pref_addr,
   output logic [4:0]               icache_pref_idx,
   output logic [7:0]               icache_pref_id,
   output logic                     icache_pref_wEN
);

   localparam int IDX_W = (PF_LINES > 1) ? $clog2(PF_LINES) : 1;
   localparam int CNT_W = $clog2(PF_LINES + 1);
   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

   state_t              state, state_nxt;
   logic [SYS_XLEN-1:0] next_addr;
   logic [CNT_W-1:0]    issued;
   logic [PF_LINES-1:0] tbl_valid, valid_nxt;
   logic [3:0]          tbl_tag [PF_LINES];
   logic [4:0]          tbl_idx [PF_LINES];
   logic [7:0]          tbl_id  [PF_LINES];

   logic                free_any, hit, start, load_ok, accept;
   logic [IDX_W-1:0]    free_sel, hit_sel;
   logic [SYS_XLEN-1:0] base_addr;
   logic                unused_bits;

   assign unused_bits = ^{icache_req_addr[2], icache_req_addr[1], icache_req_addr[0][2:0]};
   assign base_addr   = {icache_req_addr[0][SYS_XLEN-1:3], 3'b000} + SYS_XLEN'(8);

   // Lowest-numbered free entry and lowest-numbered tag match.
   always_comb begin
      free_any = 1'b0;
      free_sel = '0;
      hit      = 1'b0;
      hit_sel  = '0;
      for (int i = PF_LINES - 1; i >= 0; i--) begin
         if (!tbl_valid[i]) begin
            free_any = 1'b1;
            free_sel = IDX_W'(i);
         end
         if (tbl_valid[i] && (Imem2pref_tag != 4'd0) && (tbl_tag[i] == Imem2pref_tag)) begin
            hit     = 1'b1;
            hit_sel = IDX_W'(i);
         end
      end
   end

   assign start   = want_to_fetch && (cachemem_valid != 3'b111) && ((state == IDLE) || branch);
   assign load_ok = (state == ISSUE) && !pf_bus_priority && free_any;
   assign accept  = load_ok && (Imem2pref_response != 4'd0) && !branch;

   always_comb begin
      valid_nxt = tbl_valid;
      if (hit)    valid_nxt[hit_sel]  = 1'b0;
      if (accept) valid_nxt[free_sel] = 1'b1;
      if (branch) valid_nxt = '0;
   end

   always_comb begin
      state_nxt        = state;
      icache_pref_done = (state == IDLE);
      icache_pref_cmd  = load_ok ? BUS_LOAD : BUS_NONE;
      icache_pref_addr = next_addr;
      icache_pref_wEN  = hit;
      icache_pref_idx  = hit ? tbl_idx[hit_sel] : next_addr[7:3];
      icache_pref_id   = hit ? tbl_id[hit_sel]  : next_addr[15:8];
      if (branch) begin
         state_nxt = start ? ISSUE : IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (accept && (issued == CNT_W'(PF_LINES - 1))) state_nxt = DRAIN;
            DRAIN:   if (valid_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         next_addr <= '0;
         issued    <= '0;
         tbl_valid <= '0;
         for (int i = 0; i < PF_LINES; i++) begin
            tbl_tag[i] <= '0;
            tbl_idx[i] <= '0;
            tbl_id[i]  <= '0;
         end
      end else begin
         tbl_valid <= valid_nxt;
         if (start) begin
            next_addr <= base_addr;
            issued    <= '0;
         end else if (accept) begin
            next_addr          <= next_addr + SYS_XLEN'(8);
            issued             <= issued + CNT_W'(1);
            tbl_tag[free_sel]  <= Imem2pref_response;
            tbl_idx[free_sel]  <= next_addr[7:3];
            tbl_id[free_sel]   <= next_addr[15:8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_icache_prefetch.sv
`default_nettype none
// ============================================================================
// tb_icache_prefetch : vector-table and scoreboard bench for icache_prefetch
// Revision 1.0
// ============================================================================
module tb_icache_prefetch;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [3:0]        resp = '0;
   logic [3:0]        rtag = '0;
   logic              prio = 1'b0;
   logic              br = 1'b0;
   logic [2:0][31:0]  req_addr = '0;
   logic [2:0]        cv = '0;
   logic              want = 1'b0;
   logic              done;
   logic [1:0]        cmd;
   logic [31:0]       addr;
   logic [4:0]        idx;
   logic [7:0]        id;
   logic              wen;

   icache_prefetch #(.PF_LINES(4), .SYS_XLEN(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .Imem2pref_response (resp),
      .Imem2pref_tag      (rtag),
      .pf_bus_priority    (prio),
      .branch             (br),
      .icache_req_addr    (req_addr),
      .cachemem_valid     (cv),
      .want_to_fetch      (want),
      .icache_pref_done   (done),
      .icache_pref_cmd    (cmd),
      .icache_pref_addr   (addr),
      .icache_pref_idx    (idx),
      .icache_pref_id     (id),
      .icache_pref_wEN    (wen)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        done;
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [4:0]  idx;
      logic [7:0]  id;
      logic        wen;
   } out_t;

   typedef struct {
      logic        want;
      logic [2:0]  cv;
      logic [31:0] a0;
      logic        prio;
      logic        br;
      logic [3:0]  resp;
      logic [3:0]  rtag;
      out_t        exp;
   } vec_t;

   vec_t vecs[$];
   out_t sb[$];
   int   checks = 0;
   int   passed = 0;

   function automatic out_t mk_out(logic d, logic [1:0] c, logic [31:0] a,
                                   logic [4:0] x, logic [7:0] t, logic w);
      out_t o;
      o.done = d; o.cmd = c; o.addr = a; o.idx = x; o.id = t; o.wen = w;
      return o;
   endfunction

   task automatic add(logic w, logic [2:0] c, logic [31:0] a0, logic p, logic b,
                      logic [3:0] rs, logic [3:0] rt, out_t e);
      vec_t v;
      v.want = w; v.cv = c; v.a0 = a0; v.prio = p; v.br = b;
      v.resp = rs; v.rtag = rt; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic compare(string name);
      out_t got, exp;
      got = {done, cmd, addr, idx, id, wen};
      checks++;
      if (sb.size() == 0) begin
         $display("FAIL %s: scoreboard empty, got done=%0b cmd=%0d addr=%h", name, done, cmd, addr);
      end else begin
         exp = sb.pop_front();
         if (got !== exp)
            $display("FAIL %s: got done=%0b cmd=%0d addr=%h idx=%0d id=%h wen=%0b, expected done=%0b cmd=%0d addr=%h idx=%0d id=%h wen=%0b",
                     name, got.done, got.cmd, got.addr, got.idx, got.id, got.wen,
                     exp.done, exp.cmd, exp.addr, exp.idx, exp.id, exp.wen);
         else
            passed++;
      end
   endtask

   task automatic apply(vec_t v, int n);
      @(negedge clk);
      want = v.want; cv = v.cv; req_addr[0] = v.a0; prio = v.prio;
      br = v.br; resp = v.resp; rtag = v.rtag;
      sb.push_back(v.exp);
      #1;
      compare($sformatf("vec%0d", n));
   endtask

   task automatic idle_inputs();
      want = 1'b0; cv = '0; prio = 1'b0; br = 1'b0; resp = '0; rtag = '0;
   endtask

   initial begin
      // Basic trigger from 0x8, four accepted loads, drain with returns.
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(1, 0, 32'h0,  5'd0, 8'h00, 0));
      add(1, 3'b000, 32'h8,        0, 0, 4'd0, 4'd0, mk_out(1, 0, 32'h0,  5'd0, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(0, 1, 32'h10, 5'd2, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd1, 4'd0, mk_out(0, 1, 32'h10, 5'd2, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd2, 4'd0, mk_out(0, 1, 32'h18, 5'd3, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd3, 4'd0, mk_out(0, 1, 32'h20, 5'd4, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd4, 4'd0, mk_out(0, 1, 32'h28, 5'd5, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(0, 0, 32'h30, 5'd6, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd3, mk_out(0, 0, 32'h30, 5'd4, 8'h00, 1));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd3, mk_out(0, 0, 32'h30, 5'd6, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd1, mk_out(0, 0, 32'h30, 5'd2, 8'h00, 1));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd2, mk_out(0, 0, 32'h30, 5'd3, 8'h00, 1));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd4, mk_out(0, 0, 32'h30, 5'd5, 8'h00, 1));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(1, 0, 32'h30, 5'd6, 8'h00, 0));
      // Bus priority stall, then branch with two tags outstanding.
      add(1, 3'b011, 32'h12345678, 0, 0, 4'd0, 4'd0, mk_out(1, 0, 32'h30,       5'd6,  8'h00, 0));
      add(0, 3'b000, 32'h0,        1, 0, 4'd5, 4'd0, mk_out(0, 0, 32'h12345680, 5'd16, 8'h56, 0));
      add(0, 3'b000, 32'h0,        1, 0, 4'd5, 4'd0, mk_out(0, 0, 32'h12345680, 5'd16, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(0, 1, 32'h12345680, 5'd16, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd7, 4'd0, mk_out(0, 1, 32'h12345680, 5'd16, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd8, 4'd0, mk_out(0, 1, 32'h12345688, 5'd17, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 1, 4'd0, 4'd0, mk_out(0, 1, 32'h12345690, 5'd18, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(1, 0, 32'h12345690, 5'd18, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd7, mk_out(1, 0, 32'h12345690, 5'd18, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd8, mk_out(1, 0, 32'h12345690, 5'd18, 8'h56, 0));
      // All slots hit: no trigger.
      add(1, 3'b111, 32'h100,      0, 0, 4'd0, 4'd0, mk_out(1, 0, 32'h12345690, 5'd18, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(1, 0, 32'h12345690, 5'd18, 8'h56, 0));
      // Address wrap, simultaneous return and acceptance.
      add(1, 3'b100, 32'hFFFFFFFC, 0, 0, 4'd0, 4'd0, mk_out(1, 0, 32'h12345690, 5'd18, 8'h56, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd9, 4'd0, mk_out(0, 1, 32'h0,  5'd0, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'hA, 4'd9, mk_out(0, 1, 32'h8,  5'd0, 8'h00, 1));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'hA, mk_out(0, 1, 32'h10, 5'd1, 8'h00, 1));
      // Branch together with a fresh trigger restarts from the new address.
      add(1, 3'b000, 32'h40,       0, 1, 4'd0, 4'd0, mk_out(0, 1, 32'h10, 5'd2, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(0, 1, 32'h48, 5'd9, 8'h00, 0));
      add(1, 3'b000, 32'h800,      0, 0, 4'd0, 4'd0, mk_out(0, 1, 32'h48, 5'd9, 8'h00, 0));
      add(0, 3'b000, 32'h0,        0, 0, 4'd0, 4'd0, mk_out(0, 1, 32'h48, 5'd9, 8'h00, 0));

      req_addr = '0;
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(mk_out(1, 0, 32'h0, 5'd0, 8'h00, 0));
      compare("reset_state");
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // Asynchronous reset while in ISSUE takes effect without a clock edge.
      @(negedge clk);
      idle_inputs();
      #2;
      rst = 1'b0;
      #1;
      sb.push_back(mk_out(1, 0, 32'h0, 5'd0, 8'h00, 0));
      compare("reset_mid_issue");
      @(negedge clk);
      rst = 1'b1;
      #1;
      sb.push_back(mk_out(1, 0, 32'h0, 5'd0, 8'h00, 0));
      compare("after_reset_idle");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
